// File: rtl/systolic_ctrl.sv
// Sequencer for a 2x2 output-stationary systolic array: clears it, feeds skewed operands, drains, captures results.
// States: IDLE wait start | CLR clear accumulators | FEED skewed operands | DRAIN zero operands | FLUSH wait done | OUT hold result
module systolic_ctrl #(
  parameter int datawith   = 16,
  parameter int array_size = 2,
  parameter int DRAIN_CYC  = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*datawith-1:0] a_mat,
  input  logic [4*datawith-1:0] b_mat,
  output logic                  busy,
  output logic                  arr_rst_n,
  output logic                  systolic_en,
  output logic                  read_all_data,
  output logic [2*datawith-1:0] data_in,
  output logic [2*datawith-1:0] weight_in,
  input  logic [4*datawith-1:0] array_result,
  input  logic                  array_done,
  output logic [4*datawith-1:0] res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  err
);

  localparam int FEED_STEPS = 2 * array_size - 1;
  localparam int CNT_MAX = (TIMEOUT > DRAIN_CYC) ?
                           ((TIMEOUT > FEED_STEPS) ? TIMEOUT : FEED_STEPS) :
                           ((DRAIN_CYC > FEED_STEPS) ? DRAIN_CYC : FEED_STEPS);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    DRAIN,
    FLUSH,
    OUT
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [4*datawith-1:0] a_q, a_nxt;
  logic [4*datawith-1:0] b_q, b_nxt;
  logic [4*datawith-1:0] res_nxt;
  logic                  err_nxt;
  logic                  busy_nxt, arr_rst_n_nxt, en_nxt, rad_nxt, valid_nxt;
  logic [2*datawith-1:0] din_nxt, win_nxt;
  int                    k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      busy          <= 1'b0;
      arr_rst_n     <= 1'b0;
      systolic_en   <= 1'b0;
      read_all_data <= 1'b0;
      data_in       <= '0;
      weight_in     <= '0;
      res_data      <= '0;
      res_valid     <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      a_q           <= a_nxt;
      b_q           <= b_nxt;
      busy          <= busy_nxt;
      arr_rst_n     <= arr_rst_n_nxt;
      systolic_en   <= en_nxt;
      read_all_data <= rad_nxt;
      data_in       <= din_nxt;
      weight_in     <= win_nxt;
      res_data      <= res_nxt;
      res_valid     <= valid_nxt;
      err           <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a_q;
    b_nxt     = b_q;
    res_nxt   = res_data;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLR;
          a_nxt     = a_mat;
          b_nxt     = b_mat;
          err_nxt   = 1'b0;
        end
      end
      CLR: begin
        state_nxt = FEED;
        cnt_nxt   = CW'(FEED_STEPS - 1);
      end
      FEED: begin
        if (cnt == '0) begin
          if (DRAIN_CYC > 0) begin
            state_nxt = DRAIN;
            cnt_nxt   = CW'(DRAIN_CYC - 1);
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = CW'(TIMEOUT - 1);
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(TIMEOUT - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      FLUSH: begin
        // array_done wins over a coincident terminal count
        if (array_done || cnt == '0) begin
          state_nxt = OUT;
          res_nxt   = array_result;
          err_nxt   = !array_done;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      OUT: begin
        if (res_valid && res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without adding latency.
  always_comb begin
    busy_nxt      = (state_nxt != IDLE);
    arr_rst_n_nxt = (state_nxt != CLR);
    en_nxt        = (state_nxt == FEED) || (state_nxt == DRAIN) || (state_nxt == FLUSH);
    rad_nxt       = (state_nxt == FLUSH);
    valid_nxt     = (state_nxt == OUT);
    din_nxt       = '0;
    win_nxt       = '0;
    k             = 0;
    if (state_nxt == FEED) begin
      k = FEED_STEPS - 1 - int'(cnt_nxt);
      for (int i = 0; i < 2; i++) begin
        if (k >= i && k - i <= 1)
          din_nxt[i*datawith +: datawith] = a_q[(2*i + (k - i))*datawith +: datawith];
      end
      for (int j = 0; j < 2; j++) begin
        if (k >= j && k - j <= 1)
          win_nxt[j*datawith +: datawith] = b_q[(2*(k - j) + j)*datawith +: datawith];
      end
    end
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter datawith, default 16, operand/result element width.
REQ-002 SHALL have parameter array_size, default 2, array dimension; only 2 is supported.
REQ-003 SHALL have parameter DRAIN_CYC, default 3, zero-operand cycles after the last operand.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum FLUSH cycles waiting for array_done.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-008 a_mat  in  4*datawith  matrix A; element A[i][j] at bits [(2i+j)*datawith +: datawith].
REQ-009 b_mat  in  4*datawith  matrix B; same packing.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 arr_rst_n  out  1  active-low accumulator clear to the array.
REQ-012 systolic_en  out  1  array compute enable.
REQ-013 read_all_data  out  1  array drain/finish indication.
REQ-014 data_in  out  2*datawith  row operands; row i at [i*datawith +: datawith].
REQ-015 weight_in  out  2*datawith  column operands; column j at [j*datawith +: datawith].
REQ-016 array_result  in  4*datawith  array accumulators; C[i][j] at [(2i+j)*datawith +: datawith].
REQ-017 array_done  in  1  array compute_done.
REQ-018 res_data  out  4*datawith  captured result, same packing as array_result.
REQ-019 res_valid  out  1  result available.
REQ-020 res_ready  in  1  consumer accepts result.
REQ-021 err  out  1  set when the last job ended by timeout.

Function
REQ-022 FSM states SHALL be IDLE, CLR, FEED, DRAIN, FLUSH, OUT.
REQ-023 IDLE with start=1 SHALL register a_mat/b_mat, clear err and go to CLR; start outside IDLE SHALL be ignored.
REQ-024 CLR SHALL last exactly 1 cycle with arr_rst_n=0; arr_rst_n SHALL be 1 in all other states.
REQ-025 FEED SHALL last 3 cycles, step k=0,1,2, with systolic_en=1.
REQ-026 In FEED, row i SHALL carry A[i][k-i] when 0<=k-i<=1, else 0; column j SHALL carry B[k-j][j] when 0<=k-j<=1, else 0.
REQ-027 DRAIN SHALL last DRAIN_CYC cycles, systolic_en=1, data_in=weight_in=0.
REQ-028 FLUSH SHALL drive systolic_en=1, read_all_data=1 and zero operands, and exit to OUT on array_done=1 or after TIMEOUT cycles.
REQ-029 On a timeout exit err SHALL be set to 1; it SHALL remain set until the next accepted start.
REQ-030 res_data SHALL be loaded from array_result on the FLUSH exit edge and SHALL stay stable while res_valid=1.
REQ-031 OUT SHALL hold res_valid=1 until res_valid&&res_ready, then return to IDLE; a ready already high on OUT entry SHALL complete in 1 cycle.
REQ-032 systolic_en, read_all_data and operand outputs SHALL be 0 in IDLE, CLR and OUT.
REQ-033 All outputs SHALL be registered; start-to-first-FEED latency SHALL be 2 cycles.
REQ-034 The controller SHALL NOT perform arithmetic; products wrap modulo 2^datawith in the array.

Reset
REQ-035 rst=1 SHALL force IDLE immediately, mid-job included, and discard captured operands.
REQ-036 During reset: busy, systolic_en, read_all_data, res_valid and err SHALL be 0; data_in, weight_in and res_data SHALL be 0; arr_rst_n SHALL be 0.
REQ-037 arr_rst_n SHALL go to 1 on the first clk edge after rst deasserts.

Verification
REQ-038 A=[[1,2],[3,4]], B=[[5,6],[7,8]], with the array attached, res_ready=1 -> res_data C=[[19,22],[43,50]], err=0.
REQ-039 Same job; check FEED outputs -> k0: rows {1,0}, cols {5,0}; k1: rows {2,3}, cols {7,6}; k2: rows {0,4}, cols {0,8}.
REQ-040 array_done tied 0 -> FLUSH lasts 15 cycles, then res_valid=1 with err=1.
REQ-041 res_ready low 5 cycles in OUT -> res_valid and res_data held; a start pulse during OUT is ignored.
REQ-042 rst pulse during FEED k=1 -> all outputs at reset values; a new start runs the job correctly.
REQ-043 A=B=all 0x0100 -> each C element = 0x0000 (wrap), err=0.
